// File: rtl/shift_reg_pkg.sv
// Shared types and control encodings for the shift_reg load sequencer.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sr_state_t;

    localparam logic [1:0] SR_HOLD  = 2'b00;
    localparam logic [1:0] SR_RIGHT = 2'b01;
    localparam logic [1:0] SR_LEFT  = 2'b10;

    function automatic logic [1:0] sr_dir_control(input logic dir);
        return dir ? SR_LEFT : SR_RIGHT;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter tracking the bits still to shift; last flags the final shift.
module shift_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/shift_reg_loader.sv
// Serial loader for the external shift_reg: one request word is clocked in bit by bit.
// Optional SR_VERIFY_EN adds a completion compare of the register contents (err output).
module shift_reg_loader
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_dir,
    input  logic [CNT_W-1:0] req_len,
    input  logic             abort,
    output logic [1:0]       sr_control,
    output logic             sr_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    sr_state_t        state_reg, state_next;
    logic             req_ready_reg, req_ready_next;
    logic [1:0]       sr_control_reg, sr_control_next;
    logic             sr_in_reg, sr_in_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             dir_reg, dir_next;

    logic             accept;
    logic             cnt_last;
    logic [CNT_W-1:0] len_eff;
    logic [WIDTH-1:0] aligned;

    assign accept  = req_valid & req_ready_reg;
    assign len_eff = ((req_len == '0) || (req_len > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : req_len;
    // Left loads emit MSB first, so park the N payload bits at the top of the word.
    assign aligned = req_data << (CNT_W'(WIDTH) - len_eff);

    shift_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (accept),
        .load_val(len_eff),
        .dec     (state_reg == SHIFT),
        .last    (cnt_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b0;
            sr_control_reg <= SR_HOLD;
            sr_in_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            data_reg       <= '0;
            dir_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_ready_reg  <= req_ready_next;
            sr_control_reg <= sr_control_next;
            sr_in_reg      <= sr_in_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            data_reg       <= data_next;
            dir_reg        <= dir_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT: begin
                if (abort)         state_next = IDLE;
                else if (cnt_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_next  = (state_next == IDLE);
        busy_next       = (state_next != IDLE);
        done_next       = (state_next == DONE);
        sr_control_next = SR_HOLD;
        sr_in_next      = 1'b0;
        data_next       = data_reg;
        dir_next        = dir_reg;
        if (accept) begin
            dir_next        = req_dir;
            sr_control_next = sr_dir_control(req_dir);
            if (req_dir) begin
                sr_in_next = aligned[WIDTH-1];
                data_next  = aligned << 1;
            end else begin
                sr_in_next = req_data[0];
                data_next  = req_data >> 1;
            end
        end else if ((state_reg == SHIFT) && (state_next == SHIFT)) begin
            sr_control_next = sr_control_reg;
            if (dir_reg) begin
                sr_in_next = data_reg[WIDTH-1];
                data_next  = data_reg << 1;
            end else begin
                sr_in_next = data_reg[0];
                data_next  = data_reg >> 1;
            end
        end
    end

    assign req_ready  = req_ready_reg;
    assign sr_control = sr_control_reg;
    assign sr_in      = sr_in_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

`ifdef SR_VERIFY_EN
    logic [WIDTH-1:0] cap_data_reg;
    logic [CNT_W-1:0] cap_len_reg;
    logic             err_sticky_reg;
    logic [WIDTH-1:0] target_mask;
    logic [WIDTH-1:0] got_bits;
    logic             mismatch;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign target_mask[gi] = (CNT_W'(gi) < cap_len_reg);
        end
    endgenerate

    // Right loads land in the top N bits; bring them down to line up with the data.
    assign got_bits = dir_reg ? sr_q : (sr_q >> (CNT_W'(WIDTH) - cap_len_reg));
    assign mismatch = (((got_bits ^ cap_data_reg) & target_mask) != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_data_reg   <= '0;
            cap_len_reg    <= '0;
            err_sticky_reg <= 1'b0;
        end else if (accept) begin
            cap_data_reg   <= req_data;
            cap_len_reg    <= len_eff;
            err_sticky_reg <= 1'b0;
        end else if (done_reg && mismatch) begin
            err_sticky_reg <= 1'b1;
        end
    end

    // sr_q only settles after the final shift, so the DONE-cycle compare is
    // OR-ed in directly to raise err together with done; the sticky bit holds it.
    assign err = err_sticky_reg | (done_reg & mismatch);
`else
    logic unused_sr_q;
    assign unused_sr_q = ^sr_q;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_loader.sv
// Self-checking bench for shift_reg_loader with a behavioural model of the external shift_reg.
module tb_shift_reg_loader;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef SR_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_data;
    logic          req_dir;
    logic [CW-1:0] req_len;
    logic          abort;
    logic [1:0]    sr_control;
    logic          sr_in;
    logic [W-1:0]  sr_q;
    logic          busy;
    logic          done;
    logic          err;

    logic [W-1:0]  sr_reg;
    logic          preload_en;
    logic [W-1:0]  preload_val;
    logic [W-1:0]  stuck_mask;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    shift_reg_loader #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_dir   (req_dir),
        .req_len   (req_len),
        .abort     (abort),
        .sr_control(sr_control),
        .sr_in     (sr_in),
        .sr_q      (sr_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // External 8-bit shift register: 01 shifts right (in enters MSB), 10 shifts left (in enters LSB).
    always @(posedge clock) begin
        if (preload_en)             sr_reg <= preload_val;
        else if (sr_control == 2'b01) sr_reg <= {sr_in, sr_reg[W-1:1]};
        else if (sr_control == 2'b10) sr_reg <= {sr_reg[W-2:0], sr_in};
    end
    assign sr_q = sr_reg & ~stuck_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input logic [CW-1:0] len);
        return ((len == 0) || (len > W)) ? W : int'(len);
    endfunction

    // Final register contents from the load rules: right puts data[N-1:0] on top, left on the bottom.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] pre, input logic [W-1:0] data,
                                                 input logic dir, input int n);
        logic [15:0] p, d, r;
        p = {8'h00, pre};
        d = {8'h00, data} & ((16'd1 << n) - 16'd1);
        if (dir) r = (p << n) | d;
        else     r = (p >> n) | (d << (W - n));
        return r[W-1:0];
    endfunction

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(req_ready && !busy) && t < 30) begin
            @(negedge clock);
            t++;
        end
        check(name, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_load(input logic [W-1:0] data, input logic dir, input logic [CW-1:0] len,
                            input logic [W-1:0] pre, input logic [W-1:0] exp_q, input logic exp_err);
        int n;
        logic bitv;
        n = eff_len(len);
        @(negedge clock);
        preload_en  = 1'b1;
        preload_val = pre;
        @(negedge clock);
        preload_en  = 1'b0;
        wait_idle("ready_wait");
        req_valid = 1'b1;
        req_data  = data;
        req_dir   = dir;
        req_len   = len;
        @(negedge clock);
        req_valid = 1'b0;
        req_data  = W'($urandom);
        req_dir   = 1'($urandom);
        req_len   = CW'($urandom);
        for (int k = 1; k <= n; k++) begin
            bitv = dir ? data[n-k] : data[k-1];
            check("shift_control", {30'd0, sr_control}, dir ? 32'd2 : 32'd1);
            check("shift_bit", {31'd0, sr_in}, {31'd0, bitv});
            check("shift_busy_ready_done", {29'd0, busy, req_ready, done}, 32'b100);
            check("shift_err", {31'd0, err}, 32'd0);
            @(negedge clock);
        end
        check("done_control", {30'd0, sr_control}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_err", {31'd0, err}, {31'd0, exp_err});
        check("result", {24'd0, sr_reg}, {24'd0, exp_q});
        @(negedge clock);
        check("idle_after", {29'd0, busy, req_ready, done}, 32'b010);
        check("idle_err", {31'd0, err}, {31'd0, exp_err});
        $display("load data=%02h dir=%0d len=%0d pre=%02h -> q=%02h err=%0d", data, dir, len, pre, sr_reg, err);
    endtask

    // Hold req_valid high and measure spacing between successive load starts.
    task automatic back_to_back(input logic [CW-1:0] len, input int period);
        int starts[$];
        int bad_ctrl = 0;
        bit prev = 0;
        req_valid = 1'b1;
        req_len   = len;
        req_data  = W'($urandom);
        req_dir   = 1'($urandom);
        for (int c = 0; c < 4 * period + 4; c++) begin
            @(negedge clock);
            if (sr_control == 2'b11) bad_ctrl++;
            if ((sr_control != 2'b00) && !prev) starts.push_back(c);
            prev = (sr_control != 2'b00);
        end
        req_valid = 1'b0;
        check("b2b_ctrl_never_11", bad_ctrl, 0);
        check("b2b_start_count_ge3", {31'd0, starts.size() >= 3}, 32'd1);
        for (int i = 1; i < starts.size() && i < 4; i++)
            check("b2b_period", starts[i] - starts[i-1], period);
        wait_idle("b2b_drain");
        $display("back_to_back len=%0d starts=%0d period_expected=%0d", len, starts.size(), period);
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic          dir;
        logic [CW-1:0] len;
        logic [W-1:0]  pre;
        logic [W-1:0]  exp_q;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{data: 8'hA5, dir: 1'b0, len: 4'd0,  pre: 8'h00, exp_q: 8'hA5};
        vecs[1] = '{data: 8'h0B, dir: 1'b1, len: 4'd4,  pre: 8'hF0, exp_q: 8'h0B};
        vecs[2] = '{data: 8'h3C, dir: 1'b1, len: 4'd8,  pre: 8'h55, exp_q: 8'h3C};
        vecs[3] = '{data: 8'h05, dir: 1'b0, len: 4'd3,  pre: 8'h00, exp_q: 8'hA0};
        vecs[4] = '{data: 8'h96, dir: 1'b0, len: 4'd15, pre: 8'hFF, exp_q: 8'h96};
        vecs[5] = '{data: 8'h01, dir: 1'b1, len: 4'd1,  pre: 8'h80, exp_q: 8'h01};
        vecs[6] = '{data: 8'h09, dir: 1'b0, len: 4'd4,  pre: 8'hFF, exp_q: 8'h9F};

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_data    = '0;
        req_dir     = 1'b0;
        req_len     = '0;
        abort       = 1'b0;
        preload_en  = 1'b1;
        preload_val = 8'h00;
        stuck_mask  = 8'h00;

        // Reset state and release timing
        @(negedge clock);
        @(negedge clock);
        preload_en = 1'b0;
        check("reset_outputs", {26'd0, sr_control, sr_in, done, req_ready, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clock);
        check("ready_after_edge", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 7; i++)
            run_load(vecs[i].data, vecs[i].dir, vecs[i].len, vecs[i].pre, vecs[i].exp_q, 1'b0);

        // Abort during a right load, 3 shifts in (E1..E3)
        @(negedge clock);
        preload_en = 1'b1; preload_val = 8'h00;
        @(negedge clock);
        preload_en = 1'b0;
        req_valid = 1'b1; req_data = 8'hA5; req_dir = 1'b0; req_len = 4'd0;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_control", {30'd0, sr_control}, 32'd0);
        check("abort_busy_ready_done", {29'd0, busy, req_ready, done}, 32'b010);
        check("abort_partial", {24'd0, sr_reg}, 32'hA0);
        @(negedge clock);
        check("abort_no_done", {31'd0, done}, 32'd0);
        $display("abort after 3 shifts -> q=%02h ready=%0d", sr_reg, req_ready);

        // Accept and abort on the same edge: accept wins; abort in DONE/IDLE ignored
        req_valid = 1'b1; abort = 1'b1; req_data = 8'h02; req_dir = 1'b1; req_len = 4'd2;
        @(negedge clock);
        req_valid = 1'b0; abort = 1'b0;
        check("accept_over_abort", {30'd0, sr_control}, 32'd2);
        @(negedge clock);
        check("accept_over_abort_2", {30'd0, sr_control}, 32'd2);
        @(negedge clock);
        check("done_pulse_2", {31'd0, done}, 32'd1);
        abort = 1'b1;
        @(negedge clock);
        check("abort_in_done_ignored", {29'd0, busy, req_ready, done}, 32'b010);
        @(negedge clock);
        abort = 1'b0;
        check("abort_in_idle_ignored", {29'd0, busy, req_ready, done}, 32'b010);
        check("abort_idle_control", {30'd0, sr_control}, 32'd0);
        $display("accept+abort same edge -> load completed");

        back_to_back(4'd0, 10);
        back_to_back(4'd1, 3);

        // Stuck-at-0 on sr_q[3] during an all-ones load, then a clean load
        stuck_mask = 8'h08;
        run_load(8'hFF, 1'b0, 4'd0, 8'h00, 8'hFF, VERIFY_ON);
        stuck_mask = 8'h00;
        run_load(8'h5A, 1'b1, 4'd0, 8'h00, 8'h5A, 1'b0);

        for (int i = 0; i < 25; i++) begin
            logic [W-1:0]  d, p;
            logic          dr;
            logic [CW-1:0] ln;
            d  = W'($urandom);
            p  = W'($urandom);
            dr = 1'($urandom);
            ln = CW'($urandom_range(0, 15));
            run_load(d, dr, ln, p, ref_result(p, d, dr, eff_len(ln)), 1'b0);
        end

        // Reset asserted mid-load
        req_valid = 1'b1; req_data = 8'hC3; req_dir = 1'b0; req_len = 4'd0;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_outputs", {26'd0, sr_control, sr_in, done, req_ready, busy}, 32'd0);
        check("midreset_err", {31'd0, err}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("midreset_recover", {29'd0, busy, req_ready, done}, 32'b010);
        check("midreset_control", {30'd0, sr_control}, 32'd0);
        $display("mid-load reset -> outputs cleared, ready=%0d", req_ready);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
